// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x400 @ 70 Hz timing constants, counter widths and a
//               window-decode helper. The VGA timing generator and the
//               character controller both use these definitions.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  // Horizontal timing, in pixels
  localparam int H_DISP       = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_DISP + H_FP + H_SYNC + H_BP;   // 800
  localparam int H_SYNC_START = H_DISP + H_FP;                   // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;       // 751

  // Vertical timing, in lines
  localparam int V_DISP       = 400;
  localparam int V_FP         = 12;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 35;
  localparam int V_TOTAL      = V_DISP + V_FP + V_SYNC + V_BP;   // 449
  localparam int V_SYNC_START = V_DISP + V_FP;                   // 412
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;       // 413

  // Counter widths
  localparam int PIX_W  = 10;
  localparam int LINE_W = 9;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [LINE_W-1:0] line_t;

  // True when lo <= pos <= hi (inclusive window)
  function automatic logic in_window(input int unsigned pos,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// ============================================================================
// Module      : vga_axis_counter
// Description : Modulo-TOTAL position counter for one display axis. Exposes
//               the current count, a terminal-count flag, and decodes of the
//               count it will hold after this clock (display region and sync
//               window) so the parent can register outputs aligned with it.
// Ports       : clk_i, rst_i (async, active-high), en_i (advance),
//               cnt_o (current count), tc_o (count == TOTAL-1),
//               disp_next_o / sync_next_o (decodes of the next count)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axis_counter #(
  parameter int W          = 10,
  parameter int TOTAL      = 800,
  parameter int DISP       = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o,
  output logic         disp_next_o,
  output logic         sync_next_o
);
  import vga_timing_pkg::*;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         tc;

  assign tc = (cnt_q == W'(TOTAL - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign tc_o        = tc;
  // Decoding cnt_d lets the parent register these alongside cnt_q
  assign disp_next_o = (32'(cnt_d) < 32'(DISP));
  assign sync_next_o = in_window(32'(cnt_d), SYNC_START, SYNC_END);

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : 640x400 @ 70 Hz VGA timing generator. A clock divider produces
//               the pixel-rate enable; two axis counters produce pixelCnt and
//               lineCnt; hsync/vsync/displayEn/frameStart are registered from
//               the counters' next values so they stay aligned with them.
// Ports       : clock, reset (async, active-high)
//               pixelCnt[9:0], lineCnt[8:0] - current position
//               hsync, vsync                - sync pins (polarity by param)
//               displayEn                   - visible-area qualifier
//               frameStart                  - one-clock pulse entering (0,0)
//               pixEn                       - pixel-rate enable
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_gen #(
  parameter int   H_DISP     = vga_timing_pkg::H_DISP,
  parameter int   H_FP       = vga_timing_pkg::H_FP,
  parameter int   H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int   H_BP       = vga_timing_pkg::H_BP,
  parameter int   V_DISP     = vga_timing_pkg::V_DISP,
  parameter int   V_FP       = vga_timing_pkg::V_FP,
  parameter int   V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int   V_BP       = vga_timing_pkg::V_BP,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b1,
  parameter int   CLK_DIV    = 1    // legal range 1..8
) (
  input  logic                              clock,
  input  logic                              reset,
  output logic [vga_timing_pkg::PIX_W-1:0]  pixelCnt,
  output logic [vga_timing_pkg::LINE_W-1:0] lineCnt,
  output logic                              hsync,
  output logic                              vsync,
  output logic                              displayEn,
  output logic                              frameStart,
  output logic                              pixEn
);
  import vga_timing_pkg::*;

  localparam int H_TOT    = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int H_SS     = H_DISP + H_FP;
  localparam int V_SS     = V_DISP + V_FP;
  localparam int DIV_W    = 3;

  // ---------------------------------------------------------------- divider
  logic [DIV_W-1:0] divCnt_q;
  logic [DIV_W-1:0] divCnt_d;
  logic             div_tc;

  assign div_tc   = (divCnt_q == DIV_W'(CLK_DIV - 1));
  assign divCnt_d = div_tc ? '0 : divCnt_q + 1'b1;

  // ---------------------------------------------------------- axis counters
  logic h_tc, h_disp_next, h_sync_next;
  logic v_tc, v_disp_next, v_sync_next;

  vga_axis_counter #(
    .W          (PIX_W),
    .TOTAL      (H_TOT),
    .DISP       (H_DISP),
    .SYNC_START (H_SS),
    .SYNC_END   (H_SS + H_SYNC - 1)
  ) u_h_axis (
    .clk_i       (clock),
    .rst_i       (reset),
    .en_i        (div_tc),
    .cnt_o       (pixelCnt),
    .tc_o        (h_tc),
    .disp_next_o (h_disp_next),
    .sync_next_o (h_sync_next)
  );

  // Lines advance only on the pixel update that wraps the line
  vga_axis_counter #(
    .W          (LINE_W),
    .TOTAL      (V_TOT),
    .DISP       (V_DISP),
    .SYNC_START (V_SS),
    .SYNC_END   (V_SS + V_SYNC - 1)
  ) u_v_axis (
    .clk_i       (clock),
    .rst_i       (reset),
    .en_i        (div_tc & h_tc),
    .cnt_o       (lineCnt),
    .tc_o        (v_tc),
    .disp_next_o (v_disp_next),
    .sync_next_o (v_sync_next)
  );

  // ------------------------------------------------------- output registers
  logic hsync_q, vsync_q, displayEn_q, frameStart_q, pixEn_q;
  logic hsync_d, vsync_d, displayEn_d, frameStart_d;

  assign hsync_d      = h_sync_next ? H_SYNC_POL : ~H_SYNC_POL;
  assign vsync_d      = v_sync_next ? V_SYNC_POL : ~V_SYNC_POL;
  assign displayEn_d  = h_disp_next & v_disp_next;
  // Both axes at terminal count on an update means the new position is (0,0)
  assign frameStart_d = div_tc & h_tc & v_tc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divCnt_q     <= '0;
      pixEn_q      <= 1'b0;
      frameStart_q <= 1'b0;
      hsync_q      <= ~H_SYNC_POL;
      vsync_q      <= ~V_SYNC_POL;
      displayEn_q  <= 1'b0;
    end else begin
      divCnt_q     <= divCnt_d;
      // Pulses: high only on the clock of an update
      pixEn_q      <= div_tc;
      frameStart_q <= frameStart_d;
      // Levels: hold between updates
      if (div_tc) begin
        hsync_q     <= hsync_d;
        vsync_q     <= vsync_d;
        displayEn_q <= displayEn_d;
      end
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign displayEn  = displayEn_q;
  assign frameStart = frameStart_q;
  assign pixEn      = pixEn_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed self-checking bench for vga_sync_gen. Four instances
//               share clock and reset: default timing (CLK_DIV 1 and 2) and a
//               reduced 15x8 timing (CLK_DIV 1 and 2) so frame-level behaviour
//               is reachable in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k   = 0;          // clocks since last reset release
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // d_: default CLK_DIV=1, q_: default CLK_DIV=2
  // s_: small 15x8 CLK_DIV=1, t_: small 15x8 CLK_DIV=2
  logic [9:0] d_pix, q_pix, s_pix, t_pix;
  logic [8:0] d_line, q_line, s_line, t_line;
  logic d_hs, d_vs, d_de, d_fs, d_pe;
  logic q_hs, q_vs, q_de, q_fs, q_pe;
  logic s_hs, s_vs, s_de, s_fs, s_pe;
  logic t_hs, t_vs, t_de, t_fs, t_pe;

  vga_sync_gen #(.CLK_DIV(1)) u_def (
    .clock(clk), .reset(rst), .pixelCnt(d_pix), .lineCnt(d_line),
    .hsync(d_hs), .vsync(d_vs), .displayEn(d_de), .frameStart(d_fs), .pixEn(d_pe));

  vga_sync_gen #(.CLK_DIV(2)) u_div2 (
    .clock(clk), .reset(rst), .pixelCnt(q_pix), .lineCnt(q_line),
    .hsync(q_hs), .vsync(q_vs), .displayEn(q_de), .frameStart(q_fs), .pixEn(q_pe));

  vga_sync_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .CLK_DIV(1)) u_small (
    .clock(clk), .reset(rst), .pixelCnt(s_pix), .lineCnt(s_line),
    .hsync(s_hs), .vsync(s_vs), .displayEn(s_de), .frameStart(s_fs), .pixEn(s_pe));

  vga_sync_gen #(.H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .CLK_DIV(2)) u_small2 (
    .clock(clk), .reset(rst), .pixelCnt(t_pix), .lineCnt(t_line),
    .hsync(t_hs), .vsync(t_vs), .displayEn(t_de), .frameStart(t_fs), .pixEn(t_pe));

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  task automatic advance_to(input int target);
    while (k < target) tick();
  endtask

  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (d_pix  !== 10'd0) begin n_fail++; $display("FAIL rst_pix: got %0d want 0", d_pix); end
    n_cmp++; if (d_line !== 9'd0)  begin n_fail++; $display("FAIL rst_line: got %0d want 0", d_line); end
    n_cmp++; if (d_hs !== 1'b1) begin n_fail++; $display("FAIL rst_hsync: got %b want 1", d_hs); end
    n_cmp++; if (d_vs !== 1'b0) begin n_fail++; $display("FAIL rst_vsync: got %b want 0", d_vs); end
    n_cmp++; if (d_de !== 1'b0) begin n_fail++; $display("FAIL rst_de: got %b want 0", d_de); end
    n_cmp++; if (d_fs !== 1'b0) begin n_fail++; $display("FAIL rst_fs: got %b want 0", d_fs); end
    n_cmp++; if (d_pe !== 1'b0) begin n_fail++; $display("FAIL rst_pixen: got %b want 0", d_pe); end
    n_cmp++; if (q_pe !== 1'b0) begin n_fail++; $display("FAIL rst_div2_pixen: got %b want 0", q_pe); end

    rst = 1'b0;
    k = 0;
    tick();  // k=1
    n_cmp++; if (d_pix  !== 10'd1) begin n_fail++; $display("FAIL rel_pix: got %0d want 1", d_pix); end
    n_cmp++; if (d_line !== 9'd0)  begin n_fail++; $display("FAIL rel_line: got %0d want 0", d_line); end
    n_cmp++; if (d_de !== 1'b1) begin n_fail++; $display("FAIL rel_de: got %b want 1", d_de); end
    n_cmp++; if (d_hs !== 1'b1) begin n_fail++; $display("FAIL rel_hsync: got %b want 1", d_hs); end
    n_cmp++; if (d_vs !== 1'b0) begin n_fail++; $display("FAIL rel_vsync: got %b want 0", d_vs); end
    n_cmp++; if (d_pe !== 1'b1) begin n_fail++; $display("FAIL rel_pixen: got %b want 1", d_pe); end
    n_cmp++; if (d_fs !== 1'b0) begin n_fail++; $display("FAIL rel_fs: got %b want 0", d_fs); end
    n_cmp++; if (q_pe !== 1'b0) begin n_fail++; $display("FAIL rel_div2_pixen1: got %b want 0", q_pe); end
    n_cmp++; if (q_pix !== 10'd0) begin n_fail++; $display("FAIL rel_div2_pix1: got %0d want 0", q_pix); end
    tick();  // k=2
    n_cmp++; if (q_pe !== 1'b1) begin n_fail++; $display("FAIL rel_div2_pixen2: got %b want 1", q_pe); end
    n_cmp++; if (q_pix !== 10'd1) begin n_fail++; $display("FAIL rel_div2_pix2: got %0d want 1", q_pix); end
  endtask

  // Reduced timing: H 8/2/3/2 (hsync pixels 10..12), V 4/1/1/2 (vsync line 5)
  task automatic test_small_timing();
    int n;
    advance_to(7);
    n_cmp++; if (s_de !== 1'b1) begin n_fail++; $display("FAIL s_de_p7: got %b want 1", s_de); end
    advance_to(8);
    n_cmp++; if (s_de !== 1'b0) begin n_fail++; $display("FAIL s_de_p8: got %b want 0", s_de); end
    advance_to(9);
    n_cmp++; if (s_hs !== 1'b1) begin n_fail++; $display("FAIL s_hs_p9: got %b want 1", s_hs); end
    advance_to(10);
    n_cmp++; if (s_hs !== 1'b0) begin n_fail++; $display("FAIL s_hs_p10: got %b want 0", s_hs); end
    advance_to(12);
    n_cmp++; if (s_hs !== 1'b0) begin n_fail++; $display("FAIL s_hs_p12: got %b want 0", s_hs); end
    advance_to(13);
    n_cmp++; if (s_hs !== 1'b1) begin n_fail++; $display("FAIL s_hs_p13: got %b want 1", s_hs); end
    advance_to(15);
    n_cmp++; if (s_pix !== 10'd0) begin n_fail++; $display("FAIL s_linewrap_pix: got %0d want 0", s_pix); end
    n_cmp++; if (s_line !== 9'd1) begin n_fail++; $display("FAIL s_linewrap_line: got %0d want 1", s_line); end
    advance_to(60);
    n_cmp++; if (s_de !== 1'b0) begin n_fail++; $display("FAIL s_de_l4p0: got %b want 0", s_de); end
    advance_to(67);
    n_cmp++; if (s_de !== 1'b0) begin n_fail++; $display("FAIL s_de_l4p7: got %b want 0", s_de); end
    advance_to(74);
    n_cmp++; if (s_vs !== 1'b0) begin n_fail++; $display("FAIL s_vs_l4: got %b want 0", s_vs); end
    advance_to(75);
    n_cmp++; if (s_vs !== 1'b1) begin n_fail++; $display("FAIL s_vs_l5s: got %b want 1", s_vs); end
    advance_to(89);
    n_cmp++; if (s_vs !== 1'b1) begin n_fail++; $display("FAIL s_vs_l5e: got %b want 1", s_vs); end
    advance_to(90);
    n_cmp++; if (s_vs !== 1'b0) begin n_fail++; $display("FAIL s_vs_l6: got %b want 0", s_vs); end
    advance_to(119);
    n_cmp++; if (s_pix !== 10'd14 || s_line !== 9'd7 || s_fs !== 1'b0) begin
      n_fail++; $display("FAIL s_last: got (%0d,%0d) fs=%b want (14,7) fs=0", s_pix, s_line, s_fs); end
    advance_to(120);
    n_cmp++; if (s_pix !== 10'd0 || s_line !== 9'd0 || s_fs !== 1'b1) begin
      n_fail++; $display("FAIL s_framewrap: got (%0d,%0d) fs=%b want (0,0) fs=1", s_pix, s_line, s_fs); end
    advance_to(121);
    n_cmp++; if (s_fs !== 1'b0) begin n_fail++; $display("FAIL s_fs_width: got %b want 0", s_fs); end

    // Frame period, CLK_DIV=1: 15*8 = 120 clocks
    n = 1;
    do begin tick(); n++; end while (s_fs !== 1'b1 && n < 500);
    n_cmp++; if (n != 120) begin n_fail++; $display("FAIL s_frame_period: got %0d want 120", n); end

    // CLK_DIV=2 instance reaches (0,0) at clock 240
    n_cmp++; if (t_fs !== 1'b1 || t_pix !== 10'd0 || t_line !== 9'd0) begin
      n_fail++; $display("FAIL t_framewrap: got (%0d,%0d) fs=%b want (0,0) fs=1", t_pix, t_line, t_fs); end
    tick();
    n_cmp++; if (t_fs !== 1'b0 || t_pe !== 1'b0 || t_pix !== 10'd0) begin
      n_fail++; $display("FAIL t_hold: got pix=%0d fs=%b pe=%b want pix=0 fs=0 pe=0", t_pix, t_fs, t_pe); end
    n = 0;
    do begin tick(); n++; end while (t_fs !== 1'b1 && n < 1000);
    n_cmp++; if (k != 480) begin n_fail++; $display("FAIL t_frame_period: got %0d want 240", k - 240); end
  endtask

  task automatic test_hsync_window();
    advance_to(639);
    n_cmp++; if (d_pix !== 10'd639 || d_de !== 1'b1) begin
      n_fail++; $display("FAIL h_de_639: got pix=%0d de=%b want pix=639 de=1", d_pix, d_de); end
    advance_to(640);
    n_cmp++; if (d_de !== 1'b0) begin n_fail++; $display("FAIL h_de_640: got %b want 0", d_de); end
    advance_to(655);
    n_cmp++; if (d_hs !== 1'b1) begin n_fail++; $display("FAIL h_hs_655: got %b want 1", d_hs); end
    advance_to(656);
    n_cmp++; if (d_hs !== 1'b0) begin n_fail++; $display("FAIL h_hs_656: got %b want 0", d_hs); end
    advance_to(751);
    n_cmp++; if (d_hs !== 1'b0) begin n_fail++; $display("FAIL h_hs_751: got %b want 0", d_hs); end
    advance_to(752);
    n_cmp++; if (d_hs !== 1'b1) begin n_fail++; $display("FAIL h_hs_752: got %b want 1", d_hs); end
    advance_to(799);
    n_cmp++; if (d_pix !== 10'd799 || d_line !== 9'd0) begin
      n_fail++; $display("FAIL h_799: got (%0d,%0d) want (799,0)", d_pix, d_line); end
    advance_to(800);
    n_cmp++; if (d_pix !== 10'd0 || d_line !== 9'd1 || d_de !== 1'b1 || d_fs !== 1'b0) begin
      n_fail++; $display("FAIL h_linewrap: got (%0d,%0d) de=%b fs=%b want (0,1) de=1 fs=0",
                         d_pix, d_line, d_de, d_fs); end
  endtask

  task automatic test_div2();
    int n;
    advance_to(1311);
    n_cmp++; if (q_pix !== 10'd655 || q_pe !== 1'b0 || q_hs !== 1'b1) begin
      n_fail++; $display("FAIL q_1311: got pix=%0d pe=%b hs=%b want 655 0 1", q_pix, q_pe, q_hs); end
    advance_to(1312);
    n_cmp++; if (q_pix !== 10'd656 || q_pe !== 1'b1 || q_hs !== 1'b0) begin
      n_fail++; $display("FAIL q_1312: got pix=%0d pe=%b hs=%b want 656 1 0", q_pix, q_pe, q_hs); end
    n_cmp++; if (d_pix !== 10'd512 || d_line !== 9'd1) begin
      n_fail++; $display("FAIL d_1312: got (%0d,%0d) want (512,1)", d_pix, d_line); end
    advance_to(1313);
    n_cmp++; if (q_pix !== 10'd656 || q_pe !== 1'b0 || q_hs !== 1'b0) begin
      n_fail++; $display("FAIL q_1313: got pix=%0d pe=%b hs=%b want 656 0 0", q_pix, q_pe, q_hs); end
    n = 0;
    do begin tick(); n++; end while (q_hs !== 1'b1 && n < 1000);
    n_cmp++; if (k - 1312 != 192) begin n_fail++; $display("FAIL q_hs_width: got %0d want 192", k - 1312); end
    n_cmp++; if (q_pix !== 10'd752) begin n_fail++; $display("FAIL q_hs_rise_pix: got %0d want 752", q_pix); end
  endtask

  task automatic test_mid_reset();
    int n;
    int spurious;
    n_cmp++; if (d_pix !== 10'd704 || d_hs !== 1'b0) begin
      n_fail++; $display("FAIL mr_pre: got pix=%0d hs=%b want 704 0", d_pix, d_hs); end
    rst = 1'b1;
    #1;
    n_cmp++; if (d_pix !== 10'd0 || d_line !== 9'd0 || d_hs !== 1'b1 || d_de !== 1'b0 || d_pe !== 1'b0) begin
      n_fail++; $display("FAIL mr_async: got (%0d,%0d) hs=%b de=%b pe=%b want (0,0) 1 0 0",
                         d_pix, d_line, d_hs, d_de, d_pe); end
    n_cmp++; if (s_pix !== 10'd0 || s_vs !== 1'b0) begin
      n_fail++; $display("FAIL mr_async_small: got pix=%0d vs=%b want 0 0", s_pix, s_vs); end
    repeat (3) @(negedge clk);
    n_cmp++; if (d_pix !== 10'd0 || q_pix !== 10'd0 || q_pe !== 1'b0) begin
      n_fail++; $display("FAIL mr_hold: got d=%0d q=%0d qpe=%b want 0 0 0", d_pix, q_pix, q_pe); end
    rst = 1'b0;
    k = 0;
    tick();
    n_cmp++; if (d_pix !== 10'd1 || d_line !== 9'd0 || d_fs !== 1'b0) begin
      n_fail++; $display("FAIL mr_resume: got (%0d,%0d) fs=%b want (1,0) fs=0", d_pix, d_line, d_fs); end
    spurious = 0;
    n = 1;
    while (s_fs !== 1'b1 && n < 300) begin
      if (d_fs === 1'b1 || t_fs === 1'b1) spurious++;
      tick();
      n++;
    end
    n_cmp++; if (k != 120) begin n_fail++; $display("FAIL mr_first_fs: got clock %0d want 120", k); end
    n_cmp++; if (spurious != 0) begin n_fail++; $display("FAIL mr_spurious_fs: got %0d want 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_small_timing();
    test_hsync_window();
    test_div2();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
